cla_vector_sequencer: RTL and testbench

- Sequences input vectors into one Circuit74182 carry-lookahead instance and captures its five outputs per vector.
- Typical use: sweeping all or part of the 512-entry (CN, GB, PB) input space for leakage/SPICE vector extraction.
- Sits between a host/test controller and the 74182 datapath. It drives the DUT inputs from registers and holds each vector for a programmable settle time.
- Returns {vector, outputs} records on a valid/ready stream.

---
 rtl/cla_vector_sequencer.sv | 126 ++++++++++++
 tb/tb_cla_vector_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_vector_sequencer.sv
// Steps a 74182 carry-lookahead block through a range of {CN, GB, PB} vectors.
// Each vector is held for a settle time, then the five outputs are captured and returned on a valid/ready stream.
module cla_vector_sequencer #(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [8:0] IDLE_VEC      = 9'h1FF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic [8:0] VEC_LO,
   input  logic [8:0] VEC_HI,
   output logic       CN,
   output logic [3:0] GB,
   output logic [3:0] PB,
   input  logic       PBo,
   input  logic       GBo,
   input  logic       CNX,
   input  logic       CNY,
   input  logic       CNZ,
   output logic       RES_VALID,
   input  logic       RES_READY,
   output logic [8:0] RES_VEC,
   output logic [4:0] RES_OUT,
   output logic [9:0] RES_COUNT,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, EMIT, FIN} state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   state_t     state;
   logic [8:0] drive;
   logic [8:0] cur;
   logic [8:0] endVec;
   logic [7:0] settleCount;

   assign CN = drive[8];
   assign GB = drive[7:4];
   assign PB = drive[3:0];

   // ABORT overrides every state but IDLE; in IDLE it only masks a simultaneous START.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         drive       <= IDLE_VEC;
         cur         <= 9'd0;
         endVec      <= 9'd0;
         settleCount <= 8'd0;
         RES_VALID   <= 1'b0;
         RES_VEC     <= 9'd0;
         RES_OUT     <= 5'd0;
         RES_COUNT   <= 10'd0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         if (ABORT && state != IDLE) begin
            state     <= IDLE;
            RES_VALID <= 1'b0;
            drive     <= IDLE_VEC;
            BUSY      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (START && !ABORT) begin
                     if (VEC_LO <= VEC_HI) begin
                        cur         <= VEC_LO;
                        endVec      <= VEC_HI;
                        drive       <= VEC_LO;
                        settleCount <= SETTLE_LOAD;
                        RES_COUNT   <= 10'd0;
                        BUSY        <= 1'b1;
                        state       <= SETTLE;
                     end else begin
                        ERR <= 1'b1;
                     end
                  end
               end
               SETTLE: begin
                  settleCount <= settleCount - 8'd1;
                  if (settleCount == 8'd1) begin
                     state <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  RES_OUT   <= {PBo, GBo, CNX, CNY, CNZ};
                  RES_VEC   <= cur;
                  RES_VALID <= 1'b1;
                  state     <= EMIT;
               end
               // The end test uses equality so a sweep ending at 9'h1FF stops without wrapping.
               EMIT: begin
                  if (RES_VALID && RES_READY) begin
                     RES_VALID <= 1'b0;
                     RES_COUNT <= RES_COUNT + 10'd1;
                     if (cur == endVec) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                     end else begin
                        cur         <= cur + 9'd1;
                        drive       <= cur + 9'd1;
                        settleCount <= SETTLE_LOAD;
                        state       <= SETTLE;
                     end
                  end
               end
               FIN: begin
                  drive <= IDLE_VEC;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cla_vector_sequencer.sv
// Scoreboard bench for cla_vector_sequencer: a behavioural 74182 closes the loop,
// the main process queues expected records and a negedge monitor pops and compares them.
module tb_cla_vector_sequencer;

   localparam int READY_HIGH   = 0;
   localparam int READY_TOGGLE = 1;
   localparam int READY_LOW    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       resReady = 1'b1;
   logic [8:0] vecLo = 9'd0;
   logic [8:0] vecHi = 9'd0;
   logic       cn;
   logic [3:0] gb;
   logic [3:0] pb;
   logic       pbo, gbo, cnx, cny, cnz;
   logic       resValid;
   logic [8:0] resVec;
   logic [4:0] resOut;
   logic [9:0] resCount;
   logic       busy, done, err;

   int          vectors = 0;
   int          miscompares = 0;
   int          donePulses = 0;
   int          readyMode = READY_HIGH;
   logic [13:0] expQ[$];
   bit          holdValid = 1'b0;
   logic [13:0] holdRec = 14'd0;

   // Active-low 74182 equations, written from the datasheet rather than from the design.
   function automatic logic [4:0] cla182(input logic [8:0] v);
      logic       c;
      logic [3:0] g;
      logic [3:0] p;
      logic       cx, cy, cz, gg, pp;
      c  = v[8];
      g  = ~v[7:4];
      p  = ~v[3:0];
      cx = g[0] | (p[0] & c);
      cy = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cz = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pp = &p;
      return {~pp, ~gg, cx, cy, cz};
   endfunction

   assign {pbo, gbo, cnx, cny, cnz} = cla182({cn, gb, pb});

   cla_vector_sequencer #(.SETTLE_CYCLES(2), .IDLE_VEC(9'h1FF)) dut (
      .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
      .VEC_LO(vecLo), .VEC_HI(vecHi),
      .CN(cn), .GB(gb), .PB(pb),
      .PBo(pbo), .GBo(gbo), .CNX(cnx), .CNY(cny), .CNZ(cnz),
      .RES_VALID(resValid), .RES_READY(resReady),
      .RES_VEC(resVec), .RES_OUT(resOut), .RES_COUNT(resCount),
      .BUSY(busy), .DONE(done), .ERR(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops on every handshake, checks held records stay stable and the drive matches the record.
   always @(negedge clk) begin
      logic [13:0] expRec;
      if (done) donePulses++;
      if (holdValid && resValid) checkOutput("hold_stable", 32'({resVec, resOut}), 32'(holdRec));
      holdValid = 1'b0;
      if (resValid) begin
         checkOutput("drive_during_emit", 32'({cn, gb, pb}), 32'(resVec));
         if (resReady) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_record: got vec %0h out %0h, expected none", resVec, resOut);
            end else begin
               expRec = expQ.pop_front();
               checkOutput("record", 32'({resVec, resOut}), 32'(expRec));
            end
         end else begin
            holdValid = 1'b1;
            holdRec   = {resVec, resOut};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (readyMode == READY_TOGGLE) resReady = ~resReady;
   endtask

   task automatic applyStimulus(input logic [8:0] lo, input logic [8:0] hi);
      vecLo = lo;
      vecHi = hi;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pushRange(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) expQ.push_back({9'(v), cla182(9'(v))});
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_drive"}, 32'({cn, gb, pb}), 32'h1FF);
      checkOutput({tag, "_flags"}, 32'({resValid, busy, done, err, resCount}), 32'h0);
      checkOutput({tag, "_record"}, 32'({resVec, resOut}), 32'h0);
   endtask

   task automatic waitCount(input logic [9:0] target, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (resCount == target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("wait_count", 32'(ok), 32'd1);
   endtask

   task automatic runUntilDone(input int budget, input bit checkPeriod);
      int lastRise = -1;
      bit prevV    = 1'b0;
      bit finished = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (resValid && !prevV) begin
            if (checkPeriod && lastRise >= 0) checkOutput("record_period", 32'(c - lastRise), 32'd4);
            lastRise = c;
         end
         prevV = resValid;
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("sweep_finished", 32'(finished), 32'd1);
   endtask

   initial begin
      int n;
      int d0;
      tick();
      tick();
      checkResetState("reset");
      rst = 1'b0;
      tick();

      // Single vector 0x0B5: PBo=1 GBo=0 CNX=0 CNY=0 CNZ=1 by hand.
      expQ.push_back({9'h0B5, 5'b10001});
      d0 = donePulses;
      applyStimulus(9'h0B5, 9'h0B5);
      n = 1;
      while (!resValid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("first_latency", 32'(n), 32'd4);
      checkOutput("first_vec", 32'(resVec), 32'h0B5);
      tick();
      checkOutput("single_done", 32'({done, resCount}), 32'({1'b1, 10'd1}));
      tick();
      checkOutput("single_park", 32'({cn, gb, pb}), 32'h1FF);
      checkOutput("single_idle", 32'({busy, done}), 32'd0);
      checkOutput("single_done_count", 32'(donePulses - d0), 32'd1);

      // Full sweep with no backpressure.
      pushRange(0, 511);
      d0 = donePulses;
      applyStimulus(9'h000, 9'h1FF);
      runUntilDone(4000, 1'b1);
      checkOutput("full_count", 32'(resCount), 32'd512);
      checkOutput("full_done", 32'(donePulses - d0), 32'd1);
      checkOutput("full_queue", 32'(expQ.size()), 32'd0);
      checkOutput("full_park", 32'({cn, gb, pb}), 32'h1FF);

      // Toggling backpressure over 3..6.
      pushRange(3, 6);
      d0 = donePulses;
      resReady  = 1'b1;
      readyMode = READY_TOGGLE;
      applyStimulus(9'd3, 9'd6);
      runUntilDone(200, 1'b0);
      readyMode = READY_HIGH;
      resReady  = 1'b1;
      checkOutput("toggle_count", 32'(resCount), 32'd4);
      checkOutput("toggle_done", 32'(donePulses - d0), 32'd1);
      checkOutput("toggle_queue", 32'(expQ.size()), 32'd0);

      // Abort while record 9 is held.
      pushRange(0, 8);
      d0 = donePulses;
      applyStimulus(9'h000, 9'h1FF);
      waitCount(10'd9, 100);
      readyMode = READY_LOW;
      resReady  = 1'b0;
      n = 0;
      while (!resValid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("abort_hold_vec", 32'(resVec), 32'd9);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_valid_busy", 32'({resValid, busy}), 32'd0);
      checkOutput("abort_count", 32'(resCount), 32'd9);
      checkOutput("abort_park", 32'({cn, gb, pb}), 32'h1FF);
      checkOutput("abort_no_done", 32'(donePulses - d0), 32'd0);
      checkOutput("abort_queue", 32'(expQ.size()), 32'd0);
      readyMode = READY_HIGH;
      resReady  = 1'b1;

      // Reversed range is rejected; count from the aborted sweep is kept.
      applyStimulus(9'h010, 9'h00F);
      checkOutput("err_pulse", 32'({err, busy}), 32'({1'b1, 1'b0}));
      tick();
      checkOutput("err_clear", 32'({err, busy}), 32'd0);
      checkOutput("err_count_kept", 32'(resCount), 32'd9);

      // START together with ABORT in IDLE is ignored.
      vecLo = 9'd1;
      vecHi = 9'd2;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start_abort_idle", 32'({busy, err}), 32'd0);

      // A second START during a sweep is ignored.
      pushRange(20, 22);
      d0 = donePulses;
      applyStimulus(9'd20, 9'd22);
      tick();
      vecLo = 9'd100;
      vecHi = 9'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      runUntilDone(200, 1'b0);
      checkOutput("busy_start_count", 32'(resCount), 32'd3);
      checkOutput("busy_start_done", 32'(donePulses - d0), 32'd1);
      checkOutput("busy_start_queue", 32'(expQ.size()), 32'd0);

      // Reset while vector 5 is settling.
      pushRange(0, 4);
      applyStimulus(9'h000, 9'h1FF);
      waitCount(10'd5, 100);
      checkOutput("settle_v5_drive", 32'({cn, gb, pb}), 32'd5);
      rst = 1'b1;
      tick();
      checkResetState("midreset");
      rst = 1'b0;
      tick();
      checkOutput("final_queue", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
